mash_hop_sequencer: RTL and testbench

- Run-time configuration sequencer for the NCSP MASH top.
- Accepts one frequency-hop request at a time (integer word, 24-bit fractional word, order, MASH bit, seed, optional phase offset) over a valid/ready handshake.
- Drives the MASH top's config and reset pins in a fixed timed order: load words, pulse the core reset, wait for the input-sync pipeline, optionally pulse phase-adjust, wait for the loop to settle, then report done.
- Sits between the register/SPI front end and the MASH top, in the same clock domain.

---
 rtl/mash_seq_pkg.sv | 29 ++
 rtl/mash_seq_timer.sv | 28 ++
 rtl/mash_hop_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mash_hop_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mash_seq_pkg.sv
// Shared types and constants for the MASH hop sequencer.
package mash_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRst,
    StSync,
    StPhase,
    StPsync,
    StSettle,
    StDone
  } state_e;

  localparam int unsigned DefRstCycles    = 4;
  localparam int unsigned DefSyncCycles   = 3;
  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefCntW         = 8;

  // Highest MASH order until a hop loads a real selection.
  localparam logic [1:0] SelOrderRst = 2'b11;

  // Byte lanes of the 24-bit fractional word.
  localparam int unsigned FracByteW = 8;
  localparam int unsigned FracMsbLo = 16;
  localparam int unsigned FracIsbLo = 8;
  localparam int unsigned FracLsbLo = 0;

endpackage

// File: rtl/mash_seq_timer.sv
// Loadable down-counter with a zero flag; reloaded by the sequencer at each state entry.
module mash_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] count_q;

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (i_en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/mash_hop_sequencer.sv
// Run-time hop sequencer: loads MASH config words, then walks reset, sync,
// optional phase step and settle phases before reporting done.
module mash_hop_sequencer
  import mash_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned SYNC_CYCLES   = DefSyncCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_int,
  input  logic [23:0] i_req_frac,
  input  logic [1:0]  i_req_order,
  input  logic [3:0]  i_req_mash_bit,
  input  logic [11:0] i_req_seed,
  input  logic [11:0] i_req_phase,
  input  logic        i_req_phase_en,
  input  logic        i_abort,
  output logic [7:0]  o_int,
  output logic [7:0]  o_msb,
  output logic [7:0]  o_isb,
  output logic [7:0]  o_lsb,
  output logic [1:0]  o_sel_order,
  output logic [3:0]  o_mash_bit,
  output logic [11:0] o_seed,
  output logic [11:0] o_phaseadd,
  output logic        o_phaseadjusten,
  output logic        o_mashreseten,
  output logic        o_mash_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted
);

  localparam int unsigned MaxCycles =
      (RST_CYCLES > SYNC_CYCLES) ?
      ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) :
      ((SYNC_CYCLES > SETTLE_CYCLES) ? SYNC_CYCLES : SETTLE_CYCLES);

  if ((RST_CYCLES < 1) || (SYNC_CYCLES < 1) || (SETTLE_CYCLES < 1)) begin : g_bad_cycles
    $error("mash_hop_sequencer: every phase needs at least one cycle");
  end
  if ((longint'(MaxCycles) - 64'sd1) >= (64'sd1 <<< CNT_W)) begin : g_bad_cnt_w
    $error("mash_hop_sequencer: CNT_W too narrow for the longest phase");
  end

  localparam logic [CNT_W-1:0] RstLoad    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SyncLoad   = CNT_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             accept;
  logic             abort_hop;

  logic [7:0]  int_q, msb_q, isb_q, lsb_q;
  logic [1:0]  order_q;
  logic [3:0]  mash_bit_q;
  logic [11:0] seed_q, phase_q;
  logic        phase_en_q;
  logic        mash_rst_q;
  logic        aborted_q;

  assign accept    = (state_q == StIdle) && i_req_valid && !i_abort;
  assign abort_hop = (state_q != StIdle) && i_abort;

  mash_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_en       (1'b1),
    .o_zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and timer reload; abort overrides every busy state.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort_hop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_d = StLoad;
        end
        StLoad: begin
          state_d  = StRst;
          tmr_load = 1'b1;
          tmr_val  = RstLoad;
        end
        StRst: begin
          if (tmr_zero) begin
            state_d  = StSync;
            tmr_load = 1'b1;
            tmr_val  = SyncLoad;
          end
        end
        StSync: begin
          if (tmr_zero) begin
            if (phase_en_q) begin
              state_d = StPhase;
            end else begin
              state_d  = StSettle;
              tmr_load = 1'b1;
              tmr_val  = SettleLoad;
            end
          end
        end
        StPhase: begin
          state_d  = StPsync;
          tmr_load = 1'b1;
          tmr_val  = SyncLoad;
        end
        StPsync: begin
          if (tmr_zero) begin
            state_d  = StSettle;
            tmr_load = 1'b1;
            tmr_val  = SettleLoad;
          end
        end
        StSettle: begin
          if (tmr_zero) state_d = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Moore-decoded status; ready is the only input-dependent output.
  always_comb begin
    o_req_ready     = (state_q == StIdle) && !i_abort;
    o_busy          = (state_q != StIdle);
    o_done          = (state_q == StDone);
    o_phaseadjusten = (state_q == StPhase);
  end

  // Config words are captured on the accept edge so they are stable from LOAD onward.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      int_q      <= '0;
      msb_q      <= '0;
      isb_q      <= '0;
      lsb_q      <= '0;
      order_q    <= SelOrderRst;
      mash_bit_q <= '0;
      seed_q     <= '0;
      phase_q    <= '0;
      phase_en_q <= 1'b0;
    end else if (accept) begin
      int_q      <= i_req_int;
      msb_q      <= i_req_frac[FracMsbLo +: FracByteW];
      isb_q      <= i_req_frac[FracIsbLo +: FracByteW];
      lsb_q      <= i_req_frac[FracLsbLo +: FracByteW];
      order_q    <= i_req_order;
      mash_bit_q <= i_req_mash_bit;
      seed_q     <= i_req_seed;
      phase_q    <= i_req_phase;
      phase_en_q <= i_req_phase_en;
    end
  end

  // Core reset: held from reset, raised on accept or abort, released when RST expires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mash_rst_q <= 1'b1;
    end else if (abort_hop || accept) begin
      mash_rst_q <= 1'b1;
    end else if ((state_q == StRst) && tmr_zero) begin
      mash_rst_q <= 1'b0;
    end
  end

  // One-cycle abort report.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hop;
    end
  end

  assign o_int         = int_q;
  assign o_msb         = msb_q;
  assign o_isb         = isb_q;
  assign o_lsb         = lsb_q;
  assign o_sel_order   = order_q;
  assign o_mash_bit    = mash_bit_q;
  assign o_seed        = seed_q;
  assign o_phaseadd    = phase_q;
  assign o_mashreseten = 1'b1;
  assign o_mash_rst    = mash_rst_q;
  assign o_aborted     = aborted_q;

endmodule

// File: tb/tb_mash_hop_sequencer.sv
// Randomised bench for mash_hop_sequencer against a cycle-count reference model.
module tb_mash_hop_sequencer;

  localparam int R = 4;
  localparam int S = 3;
  localparam int T = 16;

  logic        i_clk, i_rst_n;
  logic        i_req_valid, o_req_ready;
  logic [7:0]  i_req_int;
  logic [23:0] i_req_frac;
  logic [1:0]  i_req_order;
  logic [3:0]  i_req_mash_bit;
  logic [11:0] i_req_seed, i_req_phase;
  logic        i_req_phase_en, i_abort;
  logic [7:0]  o_int, o_msb, o_isb, o_lsb;
  logic [1:0]  o_sel_order;
  logic [3:0]  o_mash_bit;
  logic [11:0] o_seed, o_phaseadd;
  logic        o_phaseadjusten, o_mashreseten, o_mash_rst, o_busy, o_done, o_aborted;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: k_m is the cycle number within the hop (0 = idle).
  int          k_m, last_m;
  bit          pe_m, mrst_m, abt_m, acc_m;
  logic [61:0] cfg_m;

  localparam logic [61:0] CfgRst = {8'h0, 24'h0, 2'b11, 4'h0, 12'h0, 12'h0};

  mash_hop_sequencer #(
    .RST_CYCLES    (R),
    .SYNC_CYCLES   (S),
    .SETTLE_CYCLES (T),
    .CNT_W         (8)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_int       (i_req_int),
    .i_req_frac      (i_req_frac),
    .i_req_order     (i_req_order),
    .i_req_mash_bit  (i_req_mash_bit),
    .i_req_seed      (i_req_seed),
    .i_req_phase     (i_req_phase),
    .i_req_phase_en  (i_req_phase_en),
    .i_abort         (i_abort),
    .o_int           (o_int),
    .o_msb           (o_msb),
    .o_isb           (o_isb),
    .o_lsb           (o_lsb),
    .o_sel_order     (o_sel_order),
    .o_mash_bit      (o_mash_bit),
    .o_seed          (o_seed),
    .o_phaseadd      (o_phaseadd),
    .o_phaseadjusten (o_phaseadjusten),
    .o_mashreseten   (o_mashreseten),
    .o_mash_rst      (o_mash_rst),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_aborted       (o_aborted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    k_m    = 0;
    last_m = 0;
    pe_m   = 1'b0;
    mrst_m = 1'b1;
    abt_m  = 1'b0;
    acc_m  = 1'b0;
    cfg_m  = CfgRst;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  function automatic void model_edge();
    acc_m = 1'b0;
    if (!i_rst_n) return;
    abt_m = 1'b0;
    if (k_m != 0 && i_abort) begin
      k_m    = 0;
      abt_m  = 1'b1;
      mrst_m = 1'b1;
    end else if (k_m == 0) begin
      if (i_req_valid && !i_abort) begin
        k_m    = 1;
        acc_m  = 1'b1;
        pe_m   = i_req_phase_en;
        cfg_m  = {i_req_int, i_req_frac, i_req_order, i_req_mash_bit, i_req_seed, i_req_phase};
        last_m = pe_m ? (R + 2 * S + T + 3) : (R + S + T + 2);
        mrst_m = 1'b1;
      end
    end else begin
      if (k_m == last_m) k_m = 0;
      else k_m++;
      if (k_m == R + 2) mrst_m = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    logic [61:0] cfg_got;
    logic [6:0]  ctl_got, ctl_exp;
    cfg_got = {o_int, o_msb, o_isb, o_lsb, o_sel_order, o_mash_bit, o_seed, o_phaseadd};
    ctl_got = {o_req_ready, o_busy, o_done, o_aborted, o_mash_rst, o_phaseadjusten,
               o_mashreseten};
    ctl_exp = {(k_m == 0) && !i_abort, k_m != 0, (k_m != 0) && (k_m == last_m), abt_m,
               mrst_m, pe_m && (k_m == R + S + 2), 1'b1};
    check("cfg", 64'(cfg_got), 64'(cfg_m));
    check("ctl{rdy,busy,done,abt,mrst,padj,rsten}", 64'(ctl_got), 64'(ctl_exp));
  endtask

  task automatic tick(input logic v, input logic ab);
    @(negedge i_clk);
    i_req_valid = v;
    i_abort     = ab;
    #1;
    check_outputs();
    model_edge();
  endtask

  // Present a request until accepted, optionally abort at a given hop cycle, run to idle.
  task automatic run_hop(input int abort_at, input bit keep_valid);
    bit started = 1'b0;
    bit ended   = 1'b0;
    for (int c = 0; c < 80 && !ended; c++) begin
      tick(keep_valid || !started, (abort_at != 0) && (k_m == abort_at));
      if (acc_m) started = 1'b1;
      else if (started && k_m == 0) ended = 1'b1;
    end
    check("hop_end", 64'(ended), 64'd1);
  endtask

  task automatic rand_fields();
    i_req_int      = 8'($urandom);
    i_req_frac     = 24'($urandom);
    i_req_order    = 2'($urandom);
    i_req_mash_bit = 4'($urandom);
    i_req_seed     = 12'($urandom);
    i_req_phase    = 12'($urandom);
    i_req_phase_en = 1'($urandom);
  endtask

  initial begin
    int ab_at, hop_len;
    bit reached;
    i_rst_n     = 1'b1;
    i_req_valid = 1'b0;
    i_abort     = 1'b0;
    rand_fields();
    model_reset();
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Idle after reset.
    repeat (100) tick(1'b0, 1'b0);

    // Plain hop.
    i_req_int = 8'h20; i_req_frac = 24'hABCDEF; i_req_order = 2'b11; i_req_phase_en = 1'b0;
    run_hop(0, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // Hop with the phase step.
    i_req_phase_en = 1'b1; i_req_phase = 12'h155;
    run_hop(0, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // Abort in cycle 12.
    i_req_phase_en = 1'b0;
    run_hop(12, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // Valid held across two back-to-back hops.
    run_hop(0, 1'b1);
    rand_fields();
    run_hop(0, 1'b0);
    repeat (2) tick(1'b0, 1'b0);

    // Asynchronous reset in cycle 7 of a hop.
    rand_fields();
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      tick(k_m == 0, 1'b0);
      if (k_m == 7) reached = 1'b1;
    end
    check("reach_cycle7", 64'(reached), 64'd1);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_abort     = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    i_rst_n = 1'b1;
    rand_fields();
    run_hop(0, 1'b0);

    // Random hops with occasional aborts and idle-time abort noise.
    for (int h = 0; h < 40; h++) begin
      rand_fields();
      hop_len = i_req_phase_en ? (R + 2 * S + T + 3) : (R + S + T + 2);
      ab_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, hop_len - 1)) : 0;
      run_hop(ab_at, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 2) == 0));
    end
    repeat (30) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
